memory_arbiter: RTL
===================

# memory_arbiter

Round-robin arbiter and sequencer that shares one `memory_rtl` instance between `N_REQ` requesters. It accepts single-word read/write requests, issues exactly one command at a time on the memory's `activate`/`valid`/`wr_rd_enb` port, waits the memory's response latency, and routes `data_out`/`error` back to the requester that was granted. It sits between the requesters and `memory_rtl` in `memory_tb_top`-style tops and in the integrated design.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 32: data width.
- `RESP_LAT`, 1: cycles from the memory issue cycle to the cycle in which `mem_data_out`/`mem_error` are valid, 1..15.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `req_we`  in  N_REQ  per-requester 1 = write, 0 = read.
- `req_addr`  in  N_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  N_REQ*DATA_W  packed write data.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: request accepted.
- `done`  out  N_REQ  one-hot, one-cycle pulse: transaction complete.
- `rdata`  out  DATA_W  read data, valid with `done`.
- `err`  out  1  memory error for the completing transaction, valid with `done`.
- `busy`  out  1  high in any state other than IDLE.
- `mem_addr`  out  ADDR_W  to `memory_rtl.addr`.
- `mem_data_in`  out  DATA_W  to `memory_rtl.data_in`.
- `mem_valid`  out  1  to `memory_rtl.valid`.
- `mem_activate`  out  1  to `memory_rtl.activate`.
- `mem_wr_rd_enb`  out  1  to `memory_rtl.wr_rd_enb`, 1 = write.
- `mem_data_out`  in  DATA_W  from `memory_rtl.data_out`.
- `mem_error`  in  1  from `memory_rtl.error`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` bit is set, pick a winner round-robin. Register the winner index, `we`, `addr` and `wdata`. Go to ISSUE.
- ISSUE, 1 cycle:
  - Drive `mem_activate=1`, `mem_valid=1`, `mem_wr_rd_enb=we`, `mem_addr`, `mem_data_in`.
  - Pulse `gnt[winner]`.
  - Load the latency counter with `RESP_LAT-1`. Go to WAIT.
- WAIT: decrement the counter each cycle.
  - When the counter is 0, capture `mem_data_out` into `rdata` and `mem_error` into `err`. Go to RESP.
  - With `RESP_LAT=1`, WAIT lasts exactly one cycle.
- RESP, 1 cycle: pulse `done[winner]`, with `rdata`/`err` valid. Go to IDLE.
- Round-robin rule:
  - Search starts at `last+1` and wraps modulo `N_REQ`.
  - `last` updates to the winner in ISSUE.
  - Reset value of `last` is `N_REQ-1`, so requester 0 wins first.
- For writes, `rdata` is driven to 0 at RESP. `err` is still reported.
- Requester rules:
  - Hold `req`, `req_we`, `req_addr` and `req_wdata` stable until `gnt`.
  - Deassert `req` in the cycle after `gnt`. A `req` still high in IDLE is treated as a new request.
- `req` bits of non-winners are ignored outside IDLE. There is no queuing.
- `mem_*` command outputs are 0 in every state except ISSUE.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE.
  - `gnt`, `done`, `rdata`, `err`, `busy`, `mem_addr`, `mem_data_in`, `mem_valid`, `mem_activate`, `mem_wr_rd_enb` all go to 0.
  - Counter goes to 0; `last` goes to `N_REQ-1`.
- Reset asserted mid-transaction: the transaction is abandoned and no `done` is issued. After release, the FSM starts in IDLE.
- Latency, measured from the first cycle `req` is seen in IDLE (cycle 0):
  - `gnt` and the memory command occur in cycle 1.
  - Response is sampled in cycle 1+`RESP_LAT`.
  - `done` occurs in cycle 2+`RESP_LAT`.
- Throughput: one transaction per `RESP_LAT`+3 cycles.
- Simultaneous requests in IDLE: exactly one `gnt` is issued. `gnt` and `done` are never multi-hot.
- Wrap-around: the winner index and the search pointer wrap modulo `N_REQ`. The counter width is `$clog2(16)` = 4 bits.

## Structure
- Shared package `memory_package`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP}.
  - `mem_cmd_t` struct {we, addr, wdata}.
  - Default parameter constants.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: `req`, `last`.
  - Outputs: `winner` index and `any`.
  - `memory_arbiter` owns the FSM, the `last` register and the counter.

## Test plan
- Single write, then read: `req[0]` writes 0xDEADBEEF to addr 0x10, then `req[0]` reads addr 0x10 → `gnt[0]` at cycle 1, `done[0]` at cycle 3 (`RESP_LAT=1`), `rdata`=0xDEADBEEF, `err`=0.
- Fairness: all 4 requesters hold `req` continuously, re-raising after each `done` → grant order 0,1,2,3,0,1; exactly one `gnt` per 4 cycles.
- Latency sweep: `RESP_LAT`=3, read from requester 2 → `mem_activate` at cycle 1, capture at cycle 4, `done[2]` at cycle 5.
- Error path: memory asserts `mem_error` on a read of addr 0xFF → `done` pulses with `err`=1 and no hang; the next request proceeds normally.
- Reset mid-op: assert `reset`=0 during WAIT → all outputs 0 immediately, no `done`; after release, `req[3]` alone is granted at cycle 1.
- Idle hygiene: no `req` for 20 cycles → `mem_valid`/`mem_activate`/`busy` stay 0.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and default constants for the memory arbiter and its round-robin picker.
package memory_package;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RESP_LAT = 1;
  localparam int CNT_W        = $clog2(16);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  // Command record at the default widths, for integration tops built around the defaults.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/memory_arbiter_rr.sv
// Combinational round-robin pick: first set request after 'last', wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last) + k) % N_REQ);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory_rtl between N_REQ single-word requesters.
module memory_arbiter
  import memory_package::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESP_LAT = DEF_RESP_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  output logic                    err,
  output logic                    busy,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data_in,
  output logic                    mem_valid,
  output logic                    mem_activate,
  output logic                    mem_wr_rd_enb,
  input  logic [DATA_W-1:0]       mem_data_out,
  input  logic                    mem_error
);

  localparam int IDX_W = $clog2(N_REQ);

  // Same shape as mem_cmd_t, but sized by this instance's parameters.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  pick;
  logic              pick_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (req),
    .last   (last_q),
    .winner (pick),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          winner_d    = pick;
          cmd_d.we    = req_we[pick];
          cmd_d.addr  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          cmd_d.wdata = req_wdata[int'(pick)*DATA_W +: DATA_W];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        last_d  = winner_q;
        cnt_d   = CNT_W'(RESP_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // A write returns no data, so the requester sees zero rather than stale bus contents.
          rdata_d = cmd_q.we ? '0 : mem_data_out;
          err_d   = mem_error;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      winner_q <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      cnt_q    <= '0;
      cmd_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Pulses and the memory command decode straight from state, so reset clears them at once.
  always_comb begin
    gnt           = (state_q == ISSUE) ? (N_REQ'(1) << winner_q) : '0;
    done          = (state_q == RESP)  ? (N_REQ'(1) << winner_q) : '0;
    busy          = (state_q != IDLE);
    mem_valid     = (state_q == ISSUE);
    mem_activate  = (state_q == ISSUE);
    mem_wr_rd_enb = (state_q == ISSUE) && cmd_q.we;
    mem_addr      = (state_q == ISSUE) ? cmd_q.addr  : '0;
    mem_data_in   = (state_q == ISSUE) ? cmd_q.wdata : '0;
    rdata         = rdata_q;
    err           = err_q;
  end

endmodule
